// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter for fetch, load/store and optional boot writes (BOOT_PORT_EN)
module mem_arbiter #(
    parameter int WADDR_W = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [31:0]        if_addr,
    output logic               if_gnt,
    output logic               if_rvalid,
    input  logic               ls_req,
    input  logic               ls_we,
    input  logic [1:0]         ls_size,
    input  logic [31:0]        ls_addr,
    input  logic [31:0]        ls_wdata,
    output logic               ls_gnt,
    output logic               ls_rvalid,
    output logic [31:0]        rdata,
`ifdef BOOT_PORT_EN
    input  logic               bt_req,
    input  logic [31:0]        bt_addr,
    input  logic [31:0]        bt_wdata,
    output logic               bt_gnt,
`endif
    output logic               mem_re,
    output logic [3:0]         mem_we,
    output logic [WADDR_W-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t state_q;
    logic   prefer_ls_q;   // 1: ls wins the next ls/if tie
    logic   rd_ls_q;       // outstanding read belongs to ls (else if)

    logic        bt_req_w;
    logic [31:0] bt_addr_w;
    logic [31:0] bt_wdata_w;
    logic        bt_gnt_w;
    logic [31:0] sel_addr;
    logic        unused_addr_bits;

`ifdef BOOT_PORT_EN
    assign bt_req_w   = bt_req;
    assign bt_addr_w  = bt_addr;
    assign bt_wdata_w = bt_wdata;
    assign bt_gnt     = bt_gnt_w;
`else
    assign bt_req_w   = 1'b0;
    assign bt_addr_w  = 32'h0;
    assign bt_wdata_w = 32'h0;
`endif

    // Upper byte-address bits beyond the memory size are dropped on purpose.
    assign unused_addr_bits = ^{sel_addr[31:WADDR_W+2], bt_addr_w[1:0]};

    // Grant selection and memory command; everything is quiet in reset and RD_WAIT.
    always_comb begin
        bt_gnt_w  = 1'b0;
        ls_gnt    = 1'b0;
        if_gnt    = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 4'b0000;
        mem_wdata = 32'h0;
        sel_addr  = 32'h0;
        if (!rst && state_q == IDLE) begin
            if (bt_req_w) begin
                bt_gnt_w  = 1'b1;
                sel_addr  = bt_addr_w;
                mem_we    = 4'b1111;
                mem_wdata = bt_wdata_w;
            end else if (ls_req && (!if_req || prefer_ls_q)) begin
                ls_gnt   = 1'b1;
                sel_addr = ls_addr;
                if (ls_we) begin
                    case (ls_size)
                        2'b00: begin
                            mem_we    = 4'b0001 << ls_addr[1:0];
                            mem_wdata = {4{ls_wdata[7:0]}};
                        end
                        2'b01: begin
                            mem_we    = ls_addr[1] ? 4'b1100 : 4'b0011;
                            mem_wdata = {2{ls_wdata[15:0]}};
                        end
                        default: begin
                            mem_we    = 4'b1111;
                            mem_wdata = ls_wdata;
                        end
                    endcase
                end else begin
                    mem_re = 1'b1;
                end
            end else if (if_req) begin
                if_gnt   = 1'b1;
                sel_addr = if_addr;
                mem_re   = 1'b1;
            end
        end
        mem_addr = sel_addr[WADDR_W+1:2];
    end

    // Read return: memory data is presented in the cycle after the read strobe.
    always_comb begin
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        rdata     = 32'h0;
        if (!rst && state_q == RD_WAIT) begin
            if_rvalid = !rd_ls_q;
            ls_rvalid = rd_ls_q;
            rdata     = mem_rdata;
        end
    end

    // FSM, round-robin pointer and read-owner tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prefer_ls_q <= 1'b1;
            rd_ls_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ls_gnt) begin
                        prefer_ls_q <= 1'b0;
                        if (!ls_we) begin
                            state_q <= RD_WAIT;
                            rd_ls_q <= 1'b1;
                        end
                    end else if (if_gnt) begin
                        prefer_ls_q <= 1'b1;
                        state_q     <= RD_WAIT;
                        rd_ls_q     <= 1'b0;
                    end
                end
                RD_WAIT: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WADDR_W, default 20, giving the memory word-address width (1M words x 4 byte banks).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port if_req  input  1  instruction-fetch read request, held until granted.
REQ-005 SHALL have port if_addr  input  32  fetch byte address; bits [1:0] ignored.
REQ-006 SHALL have port if_gnt  output  1  one-cycle pulse: fetch command issued to memory.
REQ-007 SHALL have port if_rvalid  output  1  one-cycle pulse: rdata holds the fetch word.
REQ-008 SHALL have port ls_req  input  1  load/store request, held until granted.
REQ-009 SHALL have port ls_we  input  1  1 = store, 0 = load.
REQ-010 SHALL have port ls_size  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-011 SHALL have port ls_addr  input  32  load/store byte address.
REQ-012 SHALL have port ls_wdata  input  32  store data, right-aligned.
REQ-013 SHALL have port ls_gnt  output  1  one-cycle pulse: load/store command issued.
REQ-014 SHALL have port ls_rvalid  output  1  one-cycle pulse: rdata holds the load word.
REQ-015 SHALL have port rdata  output  32  raw aligned word from memory; sign/zero extension is the requester's job.
REQ-016 SHALL have port bt_req, bt_addr[31:0], bt_wdata[31:0] inputs and bt_gnt output  boot-image word-write port (only with BOOT_PORT_EN).
REQ-017 SHALL have port mem_re  output  1  memory read strobe; mem_rdata valid the following cycle.
REQ-018 SHALL have port mem_we  output  4  byte-lane write enables, bit n drives bank mn.
REQ-019 SHALL have port mem_addr  output  WADDR_W  word index = selected byte address [WADDR_W+1:2].
REQ-020 SHALL have port mem_wdata  output  32  lane-replicated write data.
REQ-021 SHALL have port mem_rdata  input  32  memory read data.

Function
REQ-022 SHALL implement FSM states IDLE, RD_WAIT; reset state IDLE.
REQ-023 In IDLE, SHALL select one requester combinationally, drive its command and pulse its gnt in the same cycle.
REQ-024 Priority SHALL be bt > {ls, if}; ls and if SHALL alternate via a last-granted pointer when both request; pointer reset value favours ls.
REQ-025 A granted read (fetch or load) SHALL assert mem_re, move to RD_WAIT; in RD_WAIT, the matching rvalid SHALL pulse with rdata = mem_rdata, then return to IDLE (read latency 1 cycle after gnt, throughput one read per 2 cycles).
REQ-026 No grant SHALL be issued in RD_WAIT; pending requests wait.
REQ-027 A granted store or boot write SHALL complete in the grant cycle and stay IDLE (one write per cycle).
REQ-028 Store lanes: byte -> mem_we = 1 << addr[1:0], wdata = {4{wdata[7:0]}}; half -> 0011 or 1100 per addr[1], wdata = {2{wdata[15:0]}}; word -> 1111, addr[1:0] ignored.
REQ-029 Boot writes SHALL always use mem_we = 1111 and wdata unmodified.
REQ-030 With no request in IDLE, mem_re = 0, mem_we = 0000, all gnt/rvalid = 0.
REQ-031 mem_re and any mem_we bit SHALL never be asserted in the same cycle.

Reset
REQ-032 While rst = 1: all gnt, rvalid, mem_re = 0, mem_we = 0000, rdata = 0, mem_addr = 0, mem_wdata = 0; state -> IDLE, pointer -> favour ls.
REQ-033 Reset asserted in RD_WAIT SHALL abort the read: no rvalid is produced afterwards.

Configuration
REQ-034 Macro BOOT_PORT_EN defined: bt_* ports exist and bt has top priority per REQ-024.
REQ-035 BOOT_PORT_EN undefined: bt_* ports absent; arbitration is two-way ls/if only; behaviour otherwise identical.

Verification
REQ-036 Fetch only: if_req=1, if_addr=0x100, mem_rdata=0x00A00093 -> if_gnt cycle 0 with mem_addr=0x40, mem_re=1; if_rvalid, rdata=0x00A00093 cycle 1.
REQ-037 Byte store: ls_we=1, ls_size=00, ls_addr=0x103, ls_wdata=0x5A -> mem_we=1000, mem_wdata=0x5A5A5A5A, mem_addr=0x40, ls_gnt same cycle.
REQ-038 Contention: if_req and ls_req (load) held high 8 cycles -> grants ls, if, ls, if alternately, every other cycle, each followed by its own rvalid.
REQ-039 Boot (BOOT_PORT_EN): bt_req high with ls_req/if_req also high, bt_addr 0,4,8 -> three consecutive bt_gnt, mem_we=1111, zero ls/if grants until bt_req drops.
REQ-040 Reset mid-read: load granted, rst=1 next cycle -> no ls_rvalid, all outputs 0, first post-reset grant goes to ls when both request.
